// File: rtl/ddr_wr_pkg.sv
// -----------------------------------------------------------------------------
// ddr_wr_pkg
// Shared constants, FSM state type and sizing helpers for the DDR write-side
// pixel packer / burst generator (ddr_wr_pack_burst).
//   PIX_PER_WORD : pixels packed into one DDR word (default build)
//   BURST_BYTES  : byte address advance per burst (default build)
//   wr_state_e   : burst FSM states
// -----------------------------------------------------------------------------
package ddr_wr_pkg;

  localparam int PIX_PER_WORD = 256 / 32;
  localparam int BURST_BYTES  = 16 * 256 / 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DATA  = 2'd2,
    FLUSH = 2'd3
  } wr_state_e;

  function automatic int pix_per_word(input int ddr_width, input int pix_width);
    return ddr_width / pix_width;
  endfunction

  function automatic int burst_bytes(input int burst_len, input int ddr_width);
    return burst_len * ddr_width / 8;
  endfunction

endpackage

// File: rtl/ddr_wr_word_fifo.sv
// -----------------------------------------------------------------------------
// ddr_wr_word_fifo
// Synchronous first-word-fall-through FIFO for packed DDR words. A word pushed
// at cycle N is presented on o_head at N+1. A push while full is accepted only
// when a pop happens in the same cycle. i_clear empties the FIFO.
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   i_push, i_push_data : write strobe and word
//   i_pop               : consume o_head (ignored when empty)
//   i_clear             : synchronous flush of all contents
//   o_head              : word at the head of the FIFO
//   o_full, o_empty     : status flags
//   o_count             : number of stored words (0..2**DEPTH_W)
// -----------------------------------------------------------------------------
module ddr_wr_word_fifo #(
  parameter int WIDTH   = 256,
  parameter int DEPTH_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_push,
  input  logic [WIDTH-1:0]   i_push_data,
  input  logic               i_pop,
  input  logic               i_clear,
  output logic [WIDTH-1:0]   o_head,
  output logic               o_full,
  output logic               o_empty,
  output logic [DEPTH_W:0]   o_count
);

  localparam int DEPTH = 1 << DEPTH_W;

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [DEPTH_W-1:0] r_wr_ptr;
  logic [DEPTH_W-1:0] r_rd_ptr;
  logic [DEPTH_W:0]   r_count;
  logic               w_do_push;
  logic               w_do_pop;

  assign o_full    = r_count[DEPTH_W];
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!rst_n || i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; the pointers/count define validity,
  // and leaving it unreset lets it map onto RAM.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
  end

endmodule

// File: rtl/ddr_wr_pack_burst.sv
// -----------------------------------------------------------------------------
// ddr_wr_pack_burst
// Packs a 32-bit pixel stream into 256-bit DDR words (first pixel in the LSBs),
// buffers them in a word FIFO and issues fixed-length DDR write bursts with
// incrementing byte addresses. frame_sof drops any partial word and, once the
// current burst (if any) completes, flushes the FIFO and rewinds the address.
// Ports:
//   clk, rst_n              : DDR user clock, synchronous active-low reset
//   frame_sof               : start-of-frame pulse
//   pix_vld/pix_data/pix_rdy: pixel stream (accepted on vld && rdy)
//   burst_req/burst_addr    : burst request and its start byte address
//   burst_ack               : one-cycle request acceptance
//   ddr_wdata/wvalid/wlast  : write beat channel, ddr_wready accepts a beat
//   pix_drop                : pixel offered while not ready
//   drop_cnt                : saturating drop count (only with DDR_WR_DROP_CNT_EN)
// Build option: define DDR_WR_DROP_CNT_EN to add the drop_cnt output.
// -----------------------------------------------------------------------------
module ddr_wr_pack_burst
  import ddr_wr_pkg::*;
#(
  parameter int                    PIX_WIDTH        = 32,
  parameter int                    DDR_WIDTH        = 256,
  parameter int                    BURST_LEN        = 16,
  parameter int                    FIFO_DEPTH_WIDTH = 5,
  parameter int                    ADDR_WIDTH       = 28,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR        = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  frame_sof,
  input  logic                  pix_vld,
  input  logic [PIX_WIDTH-1:0]  pix_data,
  output logic                  pix_rdy,
  output logic                  burst_req,
  output logic [ADDR_WIDTH-1:0] burst_addr,
  input  logic                  burst_ack,
  output logic [DDR_WIDTH-1:0]  ddr_wdata,
  output logic                  ddr_wvalid,
  output logic                  ddr_wlast,
  input  logic                  ddr_wready,
  output logic                  pix_drop
`ifdef DDR_WR_DROP_CNT_EN
  ,
  output logic [15:0]           drop_cnt
`endif
);

  localparam int PPW    = pix_per_word(DDR_WIDTH, PIX_WIDTH);
  localparam int CNT_W  = (PPW > 1) ? $clog2(PPW) : 1;
  localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  localparam logic [CNT_W-1:0]          PACK_LAST  = CNT_W'(PPW - 1);
  localparam logic [BEAT_W-1:0]         BEAT_LAST  = BEAT_W'(BURST_LEN - 1);
  localparam logic [FIFO_DEPTH_WIDTH:0] BURST_WRDS = (FIFO_DEPTH_WIDTH + 1)'(BURST_LEN);
  localparam logic [ADDR_WIDTH-1:0]     ADDR_STEP  =
    ADDR_WIDTH'(burst_bytes(BURST_LEN, DDR_WIDTH));

  wr_state_e               r_state;
  wr_state_e               w_state_nxt;
  logic [CNT_W-1:0]        r_pack_cnt;
  logic [DDR_WIDTH-1:0]    r_pack_word;
  logic [DDR_WIDTH-1:0]    w_word;
  logic                    r_flush_pend;
  logic [BEAT_W-1:0]       r_beat_cnt;
  logic [ADDR_WIDTH-1:0]   r_burst_addr;

  logic                    w_accept;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_clear;
  logic                    w_last_beat;
  logic [DDR_WIDTH-1:0]    w_fifo_head;
  logic                    w_fifo_full;
  logic                    w_fifo_empty;
  logic [FIFO_DEPTH_WIDTH:0] w_fifo_count;

  // ---------------------------------------------------------------------------
  // Pixel packer
  // ---------------------------------------------------------------------------
  // Ready is withheld while a flush is pending and when the word about to
  // complete would have nowhere to go. rst_n gates it so the stream sees
  // "not ready" (and no drops) while reset is asserted.
  assign pix_rdy  = rst_n && !r_flush_pend && !((r_pack_cnt == PACK_LAST) && w_fifo_full);
  assign pix_drop = rst_n && pix_vld && !pix_rdy;

  // A pixel arriving with frame_sof belongs to no frame and is discarded.
  assign w_accept = pix_vld && pix_rdy && !frame_sof;
  assign w_push   = w_accept && (r_pack_cnt == PACK_LAST);

  // NOTE: every combinational output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_word = r_pack_word;
    w_word[int'(r_pack_cnt) * PIX_WIDTH +: PIX_WIDTH] = pix_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pack_cnt <= '0;
    end else if (frame_sof) begin
      r_pack_cnt <= '0;
    end else if (w_accept) begin
      r_pack_cnt  <= r_pack_cnt + 1'b1;
      r_pack_word <= w_word;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)                 r_flush_pend <= 1'b0;
    else if (r_state == FLUSH)  r_flush_pend <= 1'b0;
    else if (frame_sof)         r_flush_pend <= 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Word FIFO
  // ---------------------------------------------------------------------------
  ddr_wr_word_fifo #(
    .WIDTH   (DDR_WIDTH),
    .DEPTH_W (FIFO_DEPTH_WIDTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_push),
    .i_push_data (w_word),
    .i_pop       (w_pop),
    .i_clear     (w_clear),
    .o_head      (w_fifo_head),
    .o_full      (w_fifo_full),
    .o_empty     (w_fifo_empty),
    .o_count     (w_fifo_count)
  );

  // ---------------------------------------------------------------------------
  // Burst FSM
  // ---------------------------------------------------------------------------
  assign w_last_beat = (r_beat_cnt == BEAT_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_clear     = 1'b0;
    burst_req   = 1'b0;
    ddr_wvalid  = 1'b0;
    ddr_wlast   = 1'b0;
    ddr_wdata   = '0;
    case (r_state)
      IDLE: begin
        if (r_flush_pend)                     w_state_nxt = FLUSH;
        else if (w_fifo_count >= BURST_WRDS)  w_state_nxt = REQ;
      end
      REQ: begin
        burst_req = 1'b1;
        if (burst_ack) w_state_nxt = DATA;
      end
      DATA: begin
        // A full burst was buffered before REQ, so the head is always valid.
        ddr_wvalid = 1'b1;
        ddr_wdata  = w_fifo_head;
        ddr_wlast  = w_last_beat;
        w_pop      = ddr_wready && !w_fifo_empty;
        if (ddr_wready && w_last_beat) w_state_nxt = IDLE;
      end
      FLUSH: begin
        w_clear     = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_beat_cnt <= '0;
    end else if ((r_state == DATA) && ddr_wready) begin
      r_beat_cnt <= w_last_beat ? '0 : r_beat_cnt + 1'b1;
    end
  end

  // Address wraps naturally at 2**ADDR_WIDTH.
  always_ff @(posedge clk) begin
    if (!rst_n)
      r_burst_addr <= BASE_ADDR;
    else if (r_state == FLUSH)
      r_burst_addr <= BASE_ADDR;
    else if ((r_state == DATA) && ddr_wready && w_last_beat)
      r_burst_addr <= r_burst_addr + ADDR_STEP;
  end

  assign burst_addr = r_burst_addr;

`ifdef DDR_WR_DROP_CNT_EN
  // ---------------------------------------------------------------------------
  // Saturating drop counter; a frame start restarts it and wins over a drop.
  // ---------------------------------------------------------------------------
  logic [15:0] r_drop_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || frame_sof)              r_drop_cnt <= '0;
    else if (pix_drop && (r_drop_cnt != 16'hFFFF)) r_drop_cnt <= r_drop_cnt + 1'b1;
  end

  assign drop_cnt = r_drop_cnt;
`endif

endmodule

// File: tb/tb_ddr_wr_pack_burst.sv
// -----------------------------------------------------------------------------
// tb_ddr_wr_pack_burst
// Self-checking bench for ddr_wr_pack_burst: a reset check, a table of
// handshake vectors, directed multi-cycle sequences and a randomized phase,
// all compared every cycle against a queue-based reference model.
// Define DDR_WR_DROP_CNT_EN to also cover the drop counter.
// -----------------------------------------------------------------------------
module tb_ddr_wr_pack_burst;

  localparam int         PW    = 32;
  localparam int         DW    = 256;
  localparam int         BL    = 16;
  localparam int         AW    = 28;
  localparam logic [AW-1:0] BASE = '0;
  localparam int         STEP  = ddr_wr_pkg::BURST_BYTES;
  localparam int         PPW   = ddr_wr_pkg::PIX_PER_WORD;
  localparam int         FIFO_WORDS = 32;

  localparam int PH_IDLE = 0, PH_REQ = 1, PH_DATA = 2, PH_FLUSH = 3;

  logic          clk;
  logic          rst_n;
  logic          frame_sof;
  logic          pix_vld;
  logic [PW-1:0] pix_data;
  logic          pix_rdy;
  logic          burst_req;
  logic [AW-1:0] burst_addr;
  logic          burst_ack;
  logic [DW-1:0] ddr_wdata;
  logic          ddr_wvalid;
  logic          ddr_wlast;
  logic          ddr_wready;
  logic          pix_drop;
`ifdef DDR_WR_DROP_CNT_EN
  logic [15:0]   drop_cnt;
`endif

  ddr_wr_pack_burst dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_sof  (frame_sof),
    .pix_vld    (pix_vld),
    .pix_data   (pix_data),
    .pix_rdy    (pix_rdy),
    .burst_req  (burst_req),
    .burst_addr (burst_addr),
    .burst_ack  (burst_ack),
    .ddr_wdata  (ddr_wdata),
    .ddr_wvalid (ddr_wvalid),
    .ddr_wlast  (ddr_wlast),
    .ddr_wready (ddr_wready),
    .pix_drop   (pix_drop)
`ifdef DDR_WR_DROP_CNT_EN
    ,
    .drop_cnt   (drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: pixels collect in a queue, complete words go into a
  // word queue, bursts drain BL words from the front.
  // ---------------------------------------------------------------------------
  int              m_ph;
  int unsigned     m_part[$];
  logic [DW-1:0]   m_fifo[$];
  bit              m_fp;
  logic [AW-1:0]   m_addr;
  int              m_beat;
  int              m_drop_cnt;

  // Observed DUT activity, compared against test-plan constants.
  int              s_beats, s_lasts, s_bursts, s_acc, s_drops;
  logic [AW-1:0]   s_last_addr;
  logic [DW-1:0]   s_first_data;
  bit              s_first_seen;

  logic            mon_exp_rdy, mon_exp_drop;
  int              mon_ph0, mon_sz;
  bit              mon_pop;
  logic [DW-1:0]   mon_word;

  task automatic model_reset();
    m_ph = PH_IDLE;
    m_part.delete();
    m_fifo.delete();
    m_fp = 1'b0;
    m_addr = BASE;
    m_beat = 0;
    m_drop_cnt = 0;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_pix_rdy", pix_rdy, 1'b0);
      check("rst_pix_drop", pix_drop, 1'b0);
      model_reset();
    end else begin
      mon_exp_rdy  = !m_fp && !(m_part.size() == PPW - 1 && m_fifo.size() == FIFO_WORDS);
      mon_exp_drop = pix_vld && !mon_exp_rdy;
      check("pix_rdy", pix_rdy, mon_exp_rdy);
      check("pix_drop", pix_drop, mon_exp_drop);
      check("burst_req", burst_req, m_ph == PH_REQ);
      check("burst_addr", burst_addr, m_addr);
      check("ddr_wvalid", ddr_wvalid, m_ph == PH_DATA);
      check("ddr_wlast", ddr_wlast, (m_ph == PH_DATA) && (m_beat == BL - 1));
      check("ddr_wdata", ddr_wdata,
            (m_ph == PH_DATA && m_fifo.size() > 0) ? m_fifo[0] : '0);
`ifdef DDR_WR_DROP_CNT_EN
      check("drop_cnt", drop_cnt, m_drop_cnt);
`endif
      // DUT-side statistics
      if (burst_req && burst_ack) begin
        s_bursts++;
        s_last_addr = burst_addr;
      end
      if (ddr_wvalid && ddr_wready) begin
        s_beats++;
        if (!s_first_seen) begin
          s_first_data = ddr_wdata;
          s_first_seen = 1'b1;
        end
        if (ddr_wlast) s_lasts++;
      end
      if (pix_vld && pix_rdy && !frame_sof) s_acc++;
      if (pix_drop) s_drops++;

      // Advance the model across the coming clock edge.
      mon_ph0 = m_ph;
      mon_sz  = m_fifo.size();
      mon_pop = (m_ph == PH_DATA) && ddr_wready;
      case (m_ph)
        PH_IDLE:  if (m_fp) m_ph = PH_FLUSH; else if (mon_sz >= BL) m_ph = PH_REQ;
        PH_REQ:   if (burst_ack) m_ph = PH_DATA;
        PH_DATA:  if (mon_pop) begin
                    m_beat++;
                    if (m_beat == BL) begin
                      m_beat = 0;
                      m_addr = m_addr + AW'(STEP);
                      m_ph = PH_IDLE;
                    end
                  end
        default:  m_ph = PH_IDLE;
      endcase
      if (mon_pop && m_fifo.size() > 0) void'(m_fifo.pop_front());
      if (mon_ph0 == PH_FLUSH) begin
        m_fifo.delete();
        m_addr = BASE;
      end
      if (frame_sof) begin
        m_part.delete();
      end else if (pix_vld && mon_exp_rdy) begin
        m_part.push_back(pix_data);
        if (m_part.size() == PPW) begin
          mon_word = '0;
          foreach (m_part[k]) mon_word[k*PW +: PW] = m_part[k];
          m_fifo.push_back(mon_word);
          m_part.delete();
        end
      end
      if (mon_ph0 == PH_FLUSH) m_fp = 1'b0;
      else if (frame_sof)      m_fp = 1'b1;
      if (frame_sof)                          m_drop_cnt = 0;
      else if (mon_exp_drop && m_drop_cnt < 65535) m_drop_cnt++;
    end
  end

  // ---------------------------------------------------------------------------
  // Controller-side responders
  // ---------------------------------------------------------------------------
  int ack_delay = 2;   // -1: never acknowledge
  bit ack_rand  = 1'b0;
  int wr_mode   = 0;   // 0: always ready, 1: toggle, 2: random
  int req_age   = 0;

  always @(posedge clk) begin
    #1;
    if (burst_ack) begin
      burst_ack = 1'b0;
      req_age   = 0;
    end else if (burst_req) begin
      if (ack_delay >= 0) begin
        if (req_age >= ack_delay) burst_ack = 1'b1;
        else req_age++;
      end
    end else if (ack_rand) begin
      burst_ack = ($urandom_range(0, 7) == 0);
    end
    case (wr_mode)
      0:       ddr_wready = 1'b1;
      1:       ddr_wready = !ddr_wready;
      default: ddr_wready = ($urandom_range(0, 1) == 1);
    endcase
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send_pix(input int first, input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      pix_vld  = 1'b1;
      pix_data = PW'(first + i);
    end
    tick();
    pix_vld = 1'b0;
  endtask

  task automatic pulse_sof();
    tick();
    frame_sof = 1'b1;
    tick();
    frame_sof = 1'b0;
  endtask

  task automatic wait_lasts(input int target, input int budget, input string name);
    int n = 0;
    while (s_lasts < target && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    check(name, s_lasts >= target, 1'b1);
  endtask

  task automatic wait_beats(input int target, input int budget, input string name);
    int n = 0;
    while (s_beats < target && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    check(name, s_beats >= target, 1'b1);
  endtask

  typedef struct {
    logic          sof;
    logic          vld;
    logic [PW-1:0] data;
    logic          exp_rdy;
    logic          exp_drop;
  } vec_t;

  vec_t vt[11];

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DW-1:0] exp_w0;
    int            l0, b0;

    // Vectors applied straight after reset: sof, two cycles of pending flush
    // that drop pixels, then the eight pixels 0..7 of the first word.
    vt[0] = '{1'b1, 1'b0, 32'h0, 1'b1, 1'b0};
    vt[1] = '{1'b0, 1'b1, 32'hAA, 1'b0, 1'b1};
    vt[2] = '{1'b0, 1'b1, 32'hBB, 1'b0, 1'b1};
    for (int i = 0; i < 8; i++) vt[3+i] = '{1'b0, 1'b1, PW'(i), 1'b1, 1'b0};

    rst_n = 1'b0; frame_sof = 1'b0; pix_vld = 1'b0; pix_data = '0;
    burst_ack = 1'b0; ddr_wready = 1'b1;
    s_beats = 0; s_lasts = 0; s_bursts = 0; s_acc = 0; s_drops = 0;
    s_last_addr = '1; s_first_data = '0; s_first_seen = 1'b0;
    model_reset();

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_burst_req", burst_req, 1'b0);
    check("rst_burst_addr", burst_addr, BASE);
    check("rst_wvalid", ddr_wvalid, 1'b0);
    check("rst_wlast", ddr_wlast, 1'b0);
    check("rst_wdata", ddr_wdata, '0);
    tick();
    rst_n = 1'b1;

    // Table-driven handshake vectors
    for (int i = 0; i < 11; i++) begin
      tick();
      frame_sof = vt[i].sof;
      pix_vld   = vt[i].vld;
      pix_data  = vt[i].data;
      @(negedge clk);
      check($sformatf("vec%0d_rdy", i), pix_rdy, vt[i].exp_rdy);
      check($sformatf("vec%0d_drop", i), pix_drop, vt[i].exp_drop);
    end

    // Basic burst: pixels 0..127, ack two cycles after request
    send_pix(8, 120);
    wait_lasts(1, 200, "basic_done");
    exp_w0 = '0;
    for (int k = 0; k < PPW; k++) exp_w0[k*PW +: PW] = PW'(k);
    check("basic_bursts", s_bursts, 1);
    check("basic_addr", s_last_addr, 28'h000_0000);
    check("basic_beats", s_beats, 16);
    check("basic_lasts", s_lasts, 1);
    check("basic_beat0", s_first_data, exp_w0);

    // Two more bursts from 256 contiguous pixels
    send_pix(128, 256);
    wait_lasts(3, 200, "second_done");
    check("second_bursts", s_bursts, 3);
    check("second_addr", s_last_addr, 28'h000_0400);
    check("second_beats", s_beats, 48);

    // Backpressure: wready toggles every cycle
    wr_mode = 1;
    send_pix(384, 128);
    wait_lasts(4, 300, "bp_done");
    check("bp_beats", s_beats, 64);
    check("bp_addr", s_last_addr, 28'h000_0600);
    wr_mode = 0;

    // FIFO full: no acknowledge while 300 pixels stream in
    ack_delay = -1;
    pulse_sof();
    idle(4);
    s_acc = 0; s_drops = 0;
    l0 = s_lasts;
    send_pix(1000, 300);
    idle(2);
    check("full_accepted", s_acc, 263);
    check("full_dropped", s_drops, 37);
    check("full_req_held", burst_req, 1'b1);
`ifdef DDR_WR_DROP_CNT_EN
    check("full_drop_cnt", drop_cnt, 16'd37);
`endif
    ack_delay = 2;
    wait_lasts(l0 + 2, 300, "full_drain");
    check("full_addr", s_last_addr, 28'h000_0200);

    // frame_sof at DATA beat 5 with 3 pixels pending
    pulse_sof();
    idle(4);
    l0 = s_lasts;
    send_pix(2000, 128);
    wait_lasts(l0 + 1, 200, "sofb_first");
    b0 = s_beats;
    send_pix(3000, 131);
    wait_beats(b0 + 5, 200, "sofb_beat5");
    pulse_sof();
    wait_lasts(l0 + 2, 200, "sofb_finish");
    check("sofb_addr", s_last_addr, 28'h000_0200);
    idle(4);
    send_pix(4000, 128);
    wait_lasts(l0 + 3, 200, "sofb_next");
    check("sofb_next_addr", s_last_addr, BASE);

    // Reset at beat 8 of a burst
    send_pix(5000, 128);
    l0 = s_lasts;
    b0 = s_beats;
    wait_beats(b0 + 8, 200, "rst_beat8");
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("rstb_req", burst_req, 1'b0);
    check("rstb_wvalid", ddr_wvalid, 1'b0);
    check("rstb_wlast", ddr_wlast, 1'b0);
    check("rstb_addr", burst_addr, BASE);
    check("rstb_nolast", s_lasts, l0);
    send_pix(6000, 128);
    wait_lasts(l0 + 1, 200, "rstb_next");
    check("rstb_next_addr", s_last_addr, BASE);

    // Randomized traffic checked cycle by cycle against the model
    wr_mode  = 2;
    ack_rand = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      tick();
      pix_vld   = ($urandom_range(0, 3) != 0);
      pix_data  = $urandom();
      frame_sof = ($urandom_range(0, 399) == 0);
      if ((i % 500) == 0) ack_delay = $urandom_range(0, 4);
    end
    tick();
    pix_vld = 1'b0; frame_sof = 1'b0; ack_rand = 1'b0; wr_mode = 0;
    idle(200);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
